// File: rtl/quan_bias_add_ctrl_if.sv
// rtl/quan_bias_add_ctrl_if.sv - control, bias-write and stage-drive bundle for the bias-add sequencer
interface quan_bias_add_ctrl_if #(
  parameter int bias_width     = 8,
  parameter int bias_set_width = 16,
  parameter int addr_width     = 8,
  parameter int vec_cnt_width  = 16
);
  logic                      start;
  logic [3:0]                cfg_mode;
  logic [7:0]                cfg_groups;
  logic [vec_cnt_width-1:0]  cfg_vecs;
  logic                      bias_wr_en;
  logic [addr_width-1:0]     bias_wr_addr;
  logic [bias_width-1:0]     bias_wr_data;
  logic                      vec_valid;
  logic [bias_set_width-1:0] next_bias_set;
  logic                      add_en;
  logic [3:0]                add_mode;
  logic                      out_valid;
  logic [7:0]                out_group;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    output start, cfg_mode, cfg_groups, cfg_vecs,
    output bias_wr_en, bias_wr_addr, bias_wr_data, vec_valid,
    input  next_bias_set, add_en, add_mode, out_valid, out_group, busy, done, err
  );

  modport slave (
    input  start, cfg_mode, cfg_groups, cfg_vecs,
    input  bias_wr_en, bias_wr_addr, bias_wr_data, vec_valid,
    output next_bias_set, add_en, add_mode, out_valid, out_group, busy, done, err
  );
endinterface

// File: rtl/quan_bias_add_ctrl.sv
// rtl/quan_bias_add_ctrl.sv - bias table and group/vector sequencer for the quantization bias-add stage
module quan_bias_add_ctrl #(
  parameter int bias_width     = 8,
  parameter int bias_set_width = 16,
  parameter int bias_depth     = 256,
  parameter int addr_width     = 8,
  parameter int vec_cnt_width  = 16
) (
  input logic               clk,
  input logic               reset,
  quan_bias_add_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state;
  logic [bias_width-1:0]     tbl [bias_depth];
  logic [7:0]                g;
  logic [7:0]                groups_q;
  logic [vec_cnt_width-1:0]  v;
  logic [vec_cnt_width-1:0]  vecs_q;
  logic [3:0]                mode_q;
  logic                      live;
  logic                      drain_cnt;
  logic                      add_en_q;
  logic                      out_valid_q;
  logic [7:0]                grp_d1;
  logic [7:0]                out_group_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;

  logic [addr_width-1:0]     addr_lo;
  logic [addr_width-1:0]     addr_hi;
  logic [bias_set_width-1:0] bias_set;
  logic                      start_ok;
  logic                      last_vec;
  logic                      last_grp;

  // Bias lookup from the registered group counter; held at zero until a layer is first accepted
  always_comb begin
    addr_lo  = addr_width'(g);
    addr_hi  = addr_lo;
    bias_set = '0;
    if (mode_q == 4'd1) begin
      addr_lo = addr_width'({g, 1'b0});
      addr_hi = addr_lo + addr_width'(1);
    end
    if (live) begin
      if (mode_q == 4'd1)
        bias_set = {tbl[addr_hi], tbl[addr_lo]};
      else
        bias_set = {{(bias_set_width-bias_width){1'b0}}, tbl[addr_lo]};
    end
  end

  // Start qualification and end-of-group / end-of-layer detection
  always_comb begin
    start_ok = (bus.cfg_mode == 4'd0) ||
               ((bus.cfg_mode == 4'd1) && ({1'b0, bus.cfg_groups} <= 9'(bias_depth/2)));
    last_vec = (v == vecs_q - vec_cnt_width'(1));
    last_grp = (g == groups_q - 8'd1);
  end

  // Bias table: writable only while idle, never cleared
  always_ff @(posedge clk) begin
    if (bus.bias_wr_en && state == IDLE)
      tbl[bus.bias_wr_addr] <= bus.bias_wr_data;
  end

  // Layer sequencer with the add_en / out_valid alignment pipeline and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      g           <= '0;
      v           <= '0;
      groups_q    <= '0;
      vecs_q      <= '0;
      mode_q      <= '0;
      live        <= 1'b0;
      drain_cnt   <= 1'b0;
      add_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      grp_d1      <= '0;
      out_group_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      add_en_q    <= 1'b0;
      out_valid_q <= add_en_q;
      out_group_q <= grp_d1;
      done_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (start_ok) begin
              mode_q   <= bus.cfg_mode;
              groups_q <= bus.cfg_groups;
              vecs_q   <= bus.cfg_vecs;
              g        <= '0;
              v        <= '0;
              live     <= 1'b1;
              err_q    <= 1'b0;
              if (bus.cfg_groups == 8'd0 || bus.cfg_vecs == '0) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state  <= RUN;
                busy_q <= 1'b1;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.vec_valid) begin
            // The stage latches this cycle's bias; its add happens next cycle
            add_en_q <= 1'b1;
            grp_d1   <= g;
            if (last_vec) begin
              v <= '0;
              g <= g + 8'd1;
              if (last_grp) begin
                state     <= DRAIN;
                drain_cnt <= 1'b0;
              end
            end else begin
              v <= v + vec_cnt_width'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (bus.bias_wr_en && state != IDLE)
        err_q <= 1'b1;
      if (bus.vec_valid && state != RUN)
        err_q <= 1'b1;
    end
  end

  assign bus.next_bias_set = bias_set;
  assign bus.add_en        = add_en_q;
  assign bus.add_mode      = mode_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_group     = out_group_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_quan_bias_add_ctrl.sv
// tb/tb_quan_bias_add_ctrl.sv - directed self-checking bench for quan_bias_add_ctrl
module tb_quan_bias_add_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quan_bias_add_ctrl_if bus ();
  quan_bias_add_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        vv;
    logic        chk_nbs;
    logic [15:0] nbs;
    logic        en;
    logic        ov;
    logic [7:0]  og;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tv [10];

  bit mon_on = 1'b0;
  int vv_q[$];
  int en_q[$];
  int ov_q[$];

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.add_en) en_q.push_back(cyc);
      if (bus.out_valid) ov_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.bias_wr_en   = 1'b1;
    bus.bias_wr_addr = addr;
    bus.bias_wr_data = data;
    next_cycle();
    bus.bias_wr_en   = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] mode, input logic [7:0] groups, input logic [15:0] vecs);
    bus.start      = 1'b1;
    bus.cfg_mode   = mode;
    bus.cfg_groups = groups;
    bus.cfg_vecs   = vecs;
    next_cycle();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input string name, output int ov_cnt);
    int seen;
    seen   = 0;
    ov_cnt = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
      if (bus.done) seen = 1;
      next_cycle();
    end
    chk(name, seen, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_nbs"},   bus.next_bias_set, 16'h0000);
    chk({tag, "_en"},    bus.add_en, 1'b0);
    chk({tag, "_mode"},  bus.add_mode, 4'd0);
    chk({tag, "_ov"},    bus.out_valid, 1'b0);
    chk({tag, "_og"},    bus.out_group, 8'd0);
    chk({tag, "_busy"},  bus.busy, 1'b0);
    chk({tag, "_done"},  bus.done, 1'b0);
    chk({tag, "_err"},   bus.err, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ov_cnt;
    int done_cnt;
    int gap;

    tv[0] = '{1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 1'b1, 16'h00FD, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0};
    tv[4] = '{1'b1, 1'b1, 16'h00FD, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b1, 16'h00FD, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0};
    tv[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0};
    tv[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
    tv[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};

    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.cfg_mode     = '0;
    bus.cfg_groups   = '0;
    bus.cfg_vecs     = '0;
    bus.bias_wr_en   = 1'b0;
    bus.bias_wr_addr = '0;
    bus.bias_wr_data = '0;
    bus.vec_valid    = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    next_cycle();

    // Mode 0 basic: per-cycle table from the first RUN cycle
    wr(8'd0, 8'd5);
    wr(8'd1, 8'hFD);
    do_start(4'd0, 8'd2, 16'd3);
    for (int i = 0; i < 10; i++) begin
      bus.vec_valid = tv[i].vv;
      @(negedge clk);
      if (tv[i].chk_nbs) chk($sformatf("m0_nbs[%0d]", i), bus.next_bias_set, tv[i].nbs);
      chk($sformatf("m0_en[%0d]", i), bus.add_en, tv[i].en);
      chk($sformatf("m0_ov[%0d]", i), bus.out_valid, tv[i].ov);
      if (tv[i].ov) chk($sformatf("m0_og[%0d]", i), bus.out_group, tv[i].og);
      chk($sformatf("m0_busy[%0d]", i), bus.busy, tv[i].busy);
      chk($sformatf("m0_done[%0d]", i), bus.done, tv[i].done);
      next_cycle();
    end
    bus.vec_valid = 1'b0;

    // Mode 1 pairs with a one-cycle gap
    wr(8'd0, 8'd1);
    wr(8'd1, 8'd2);
    wr(8'd2, 8'h80);
    wr(8'd3, 8'h7F);
    do_start(4'd1, 8'd2, 16'd1);
    bus.vec_valid = 1'b1;
    @(negedge clk);
    chk("m1_nbs_g0", bus.next_bias_set, 16'h0201);
    chk("m1_mode", bus.add_mode, 4'd1);
    next_cycle();
    bus.vec_valid = 1'b0;
    @(negedge clk);
    chk("m1_nbs_g1", bus.next_bias_set, 16'h7F80);
    chk("m1_en0", bus.add_en, 1'b1);
    next_cycle();
    bus.vec_valid = 1'b1;
    @(negedge clk);
    chk("m1_nbs_g1b", bus.next_bias_set, 16'h7F80);
    chk("m1_ov0", bus.out_valid, 1'b1);
    chk("m1_og0", bus.out_group, 8'd0);
    next_cycle();
    bus.vec_valid = 1'b0;
    @(negedge clk);
    chk("m1_en1", bus.add_en, 1'b1);
    chk("m1_busy", bus.busy, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("m1_ov1", bus.out_valid, 1'b1);
    chk("m1_og1", bus.out_group, 8'd1);
    next_cycle();
    @(negedge clk);
    chk("m1_done", bus.done, 1'b1);
    chk("m1_busy_low", bus.busy, 1'b0);
    next_cycle();

    // Gapped vec_valid: add_en at +1, out_valid at +2
    vv_q.delete();
    en_q.delete();
    ov_q.delete();
    mon_on = 1'b1;
    do_start(4'd0, 8'd2, 16'd3);
    for (int k = 0; k < 6; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) next_cycle();
      bus.vec_valid = 1'b1;
      vv_q.push_back(cyc);
      next_cycle();
      bus.vec_valid = 1'b0;
    end
    wait_done("gap_done", ov_cnt);
    mon_on = 1'b0;
    chk("gap_en_count", en_q.size(), 6);
    chk("gap_ov_count", ov_q.size(), 6);
    if (en_q.size() == 6 && ov_q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("gap_en_cyc[%0d]", k), en_q[k], vv_q[k] + 1);
        chk($sformatf("gap_ov_cyc[%0d]", k), ov_q[k], vv_q[k] + 2);
      end
    end

    // Errors: bad mode refused, valid start clears, write while busy dropped
    do_start(4'd2, 8'd1, 16'd1);
    @(negedge clk);
    chk("badmode_err", bus.err, 1'b1);
    chk("badmode_busy", bus.busy, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("badmode_idle", bus.busy, 1'b0);
    chk("badmode_nodone", bus.done, 1'b0);
    next_cycle();
    do_start(4'd0, 8'd1, 16'd2);
    bus.bias_wr_en   = 1'b1;
    bus.bias_wr_addr = 8'd0;
    bus.bias_wr_data = 8'h55;
    @(negedge clk);
    chk("clr_err", bus.err, 1'b0);
    chk("clr_busy", bus.busy, 1'b1);
    next_cycle();
    bus.bias_wr_en = 1'b0;
    bus.vec_valid  = 1'b1;
    @(negedge clk);
    chk("busywr_err", bus.err, 1'b1);
    chk("busywr_tbl", bus.next_bias_set, 16'h0001);
    next_cycle();
    next_cycle();
    bus.vec_valid = 1'b0;
    wait_done("busywr_done", ov_cnt);

    // Zero config with mode 1 at the 128-group boundary: accepted, done at once
    do_start(4'd1, 8'd128, 16'd0);
    @(negedge clk);
    chk("zero_done", bus.done, 1'b1);
    chk("zero_err", bus.err, 1'b0);
    chk("zero_en", bus.add_en, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("zero_en2", bus.add_en, 1'b0);
    chk("zero_done2", bus.done, 1'b0);
    next_cycle();

    // Mode 1 with 129 groups refused
    do_start(4'd1, 8'd129, 16'd1);
    @(negedge clk);
    chk("g129_err", bus.err, 1'b1);
    chk("g129_busy", bus.busy, 1'b0);
    next_cycle();

    // Zero config in mode 0: table unchanged by the earlier busy write
    do_start(4'd0, 8'd3, 16'd0);
    @(negedge clk);
    chk("zero0_done", bus.done, 1'b1);
    chk("zero0_err", bus.err, 1'b0);
    chk("zero0_tbl", bus.next_bias_set, 16'h0001);
    next_cycle();

    // Reset after 2 of 6 vectors
    do_start(4'd0, 8'd2, 16'd3);
    bus.vec_valid = 1'b1;
    next_cycle();
    next_cycle();
    bus.vec_valid = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      next_cycle();
    end
    chk("midrst_nodone", done_cnt, 0);
    do_start(4'd0, 8'd1, 16'd2);
    bus.vec_valid = 1'b1;
    next_cycle();
    next_cycle();
    bus.vec_valid = 1'b0;
    wait_done("fresh_done", ov_cnt);
    chk("fresh_ov_count", ov_cnt, 2);
    @(negedge clk);
    chk("fresh_err", bus.err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/quan_bias_add_ctrl.md
# quan_bias_add_ctrl

Sequencer for the quantization bias-add stage. Holds the per-output-channel bias table, walks output-channel groups and pixel vectors for one layer, and drives the stage's `next_bias_set`, `en` and `mode`. It compensates for the stage's internal one-cycle bias register so every sum vector meets the bias of its own channel group. It also emits a valid/group tag aligned with the stage's registered output.

## Interface
- `bias_width`, 8: bits per bias entry.
- `bias_set_width`, 16: width of `next_bias_set`, which carries two biases.
- `bias_depth`, 256: number of bias table entries.
- `addr_width`, 8: log2(`bias_depth`).
- `vec_cnt_width`, 16: width of the per-group vector count.

- `clk`, in, 1: single clock. All logic is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that launches a layer. Sampled only in IDLE.
- `cfg_mode`, in, 4: layer mode. 0 = 8x8 (one bias per group); 1 = 1x8 (two biases per group). Latched at start.
- `cfg_groups`, in, 8: number of channel groups in the layer. Latched at start.
- `cfg_vecs`, in, `vec_cnt_width`: sum vectors per group. Latched at start.
- `bias_wr_en`, in, 1: bias table write strobe.
- `bias_wr_addr`, in, `addr_width`: bias table write address.
- `bias_wr_data`, in, `bias_width`: signed bias value.
- `vec_valid`, in, 1: advance notice. The matching sum vector is on the datapath in the following cycle.
- `next_bias_set`, out, `bias_set_width`: drives the stage's `next_bias_set`.
- `add_en`, out, 1: drives the stage's `en`.
- `add_mode`, out, 4: drives the stage's `mode`.
- `out_valid`, out, 1: the stage output register holds a new result this cycle.
- `out_group`, out, 8: group index of the result flagged by `out_valid`.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle pulse when the layer is finished.
- `err`, out, 1: sticky error flag. Cleared only by `reset` or by an accepted `start`.

## Operation
- **Bias table**
  - Array of `bias_depth` x `bias_width` entries with combinational read.
  - A write takes effect at the clock edge, but only in IDLE. `bias_wr_en` outside IDLE is dropped and sets `err`.
  - The table is not cleared by reset.
- **Bias selection** uses the registered group counter `g`:
  - Mode 0: `next_bias_set = {8'h00, tbl[g]}`.
  - Mode 1: `next_bias_set = {tbl[2g+1], tbl[2g]}`, computed with `addr_width` wraparound.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start` is accepted when `cfg_mode` is 0 or 1 and, for mode 1, `cfg_groups <= bias_depth/2`.
  - On accept: latch the config, set `g = 0` and `v = 0`, clear `err`.
    - If `cfg_groups == 0` or `cfg_vecs == 0`, go to DONE.
    - Otherwise go to RUN.
  - On a refused start (bad mode or too many groups): set `err` and stay in IDLE.
- **RUN**, on each `vec_valid`:
  - If `v == cfg_vecs-1`: set `v = 0` and `g = g+1`. If this was the last group, go to DRAIN.
  - Otherwise: `v = v+1`.
- **DRAIN**
  - Lasts 2 cycles, so that the last `add_en` and the last `out_valid` both retire.
  - Then go to DONE.
  - `vec_valid` in DRAIN is ignored and sets `err`.
- **DONE:** assert `done` for 1 cycle, then return to IDLE.
- **Outside RUN:** `vec_valid` never advances `g` or `v`. It sets `err` in DRAIN, DONE and IDLE.
- **`add_mode`:** the latched mode, held until the next accepted start.

## Timing
- **Reset values:** `next_bias_set` = 0 (g=0 with table don't-care, so the output is driven from a registered 0 while in reset), `add_en` = 0, `add_mode` = 0, `out_valid` = 0, `out_group` = 0, `busy` = 0, `done` = 0, `err` = 0, state = IDLE.
- **Per-vector pipeline** for a `vec_valid` in cycle t:
  - Cycle t: `next_bias_set` already reflects the vector's group. The stage captures it into its internal bias register at the end of t, and `g`/`v` update at the same edge.
  - Cycle t+1: `add_en = 1`. The stage registers its result at the end of t+1.
  - Cycle t+2: `out_valid = 1`, and `out_group` equals the group sampled in cycle t.
- **Latency:** 2 cycles from `vec_valid` to `out_valid`.
- **Throughput:** one vector per cycle. Back-to-back `vec_valid` across a group boundary must give correct biases with no bubble.
- **`done` timing:** `done` is asserted 1 cycle after the last `out_valid`. `busy` falls in the same cycle `done` rises.
- **Reset mid-layer:** reset in any state returns to IDLE within the same edge. Any in-flight `add_en`/`out_valid` is dropped, and no `done` is issued.

## Test plan
- **Mode 0 basic.**
  - Stimulus: tbl[0]=5, tbl[1]=-3; `cfg_groups`=2, `cfg_vecs`=3; 6 back-to-back `vec_valid`.
  - Required: `next_bias_set` equals 0x0005 for vectors 0-2 and 0x00FD for vectors 3-5. `add_en` is high for 6 cycles starting 1 cycle after the first `vec_valid`. `out_group` sequence is 0,0,0,1,1,1. `done` asserts 1 cycle after the last `out_valid`.
- **Mode 1 pairs.**
  - Stimulus: tbl[0..3] = 1, 2, 0x80, 0x7F; `cfg_groups`=2, `cfg_vecs`=1; two `vec_valid` pulses with a 1-cycle gap.
  - Required: `next_bias_set` is 0x0201 for group 0 and 0x7F80 for group 1. `add_mode` = 1.
- **Gapped `vec_valid`.** Insert random 0-3 cycle gaps.
  - Required: every `add_en` occurs exactly 1 cycle after its `vec_valid`, and every `out_valid` exactly 2 cycles after. Counts match.
- **Errors.**
  - `start` with `cfg_mode`=2 → `err` = 1 and state stays IDLE.
  - Mode 1 with `cfg_groups`=129 → refused.
  - `bias_wr_en` while busy → table unchanged and `err` = 1.
  - A subsequent valid start clears `err`.
- **Zero config.** `cfg_vecs`=0 → `done` within 2 cycles of `start`, with no `add_en`.
- **Reset mid-RUN.** Assert reset after 2 of 6 vectors.
  - Required: all outputs return to their reset values on the next edge and there is no `done`. A fresh start then runs cleanly.
